// File: rtl/decim_cic_pkg.sv
// Shared constants and helpers for the decim_cic 1-bit delta-sigma decimator:
// widths, saturation limits, the bit-to-sample map and the output saturator.
package decim_cic_pkg;

    localparam int DECIM_LOG2 = 4;
    localparam int ACC_W      = 2 + 3 * DECIM_LOG2;
    localparam int OUT_W      = 14;

    localparam int OUT_MAX = 8191;
    localparam int OUT_MIN = -8192;

    typedef logic        [ACC_W-1:0] acc_t;
    typedef logic signed [ACC_W:0]   wide_t;
    typedef logic signed [OUT_W-1:0] out_t;

    // ds_in = 1 maps to +1, ds_in = 0 maps to -1 (all ones in two's complement).
    localparam acc_t DS_POS = acc_t'(1);
    localparam acc_t DS_NEG = '1;

    function automatic logic out_of_range(input wide_t y);
        return (y > wide_t'(OUT_MAX)) || (y < wide_t'(OUT_MIN));
    endfunction

    function automatic out_t sat_out(input wide_t y);
        if (y > wide_t'(OUT_MAX)) begin
            return out_t'(OUT_MAX);
        end else if (y < wide_t'(OUT_MIN)) begin
            return out_t'(OUT_MIN);
        end
        return out_t'(y);
    endfunction

endpackage

// File: rtl/decim_cic_comb_stage.sv
// One CIC comb section: output is the input minus its value at the previous
// decimation strobe, all modulo 2^ACC_W.
module cic_comb_stage
    import decim_cic_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] dout
);

    logic [ACC_W-1:0] dz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dz <= '0;
        end else if (en) begin
            dz <= din;
        end
    end

    assign dout = din - dz;

endmodule

// File: rtl/decim_cic.sv
// Third-order CIC decimator (R = 16) turning the 1-bit modulator stream into
// 14-bit signed samples. Define DECIM_CLIP_EN to add the sticky clip_o flag.
module decim_cic
    import decim_cic_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ds_in,
    input  logic                    sync_i,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid
`ifdef DECIM_CLIP_EN
    ,
    output logic                    clip_o
`endif
);

    logic [DECIM_LOG2-1:0] phase_cnt;
    logic [ACC_W-1:0]      x;
    logic [ACC_W-1:0]      i1, i2, i3;
    logic [ACC_W-1:0]      c1, c2, c3;
    logic                  dec;
    wide_t                 y;

    assign x = ds_in ? DS_POS : DS_NEG;

    // Integrators wrap freely; the comb differences cancel the overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else begin
            // NOTE: non-blocking updates make each stage see the previous stage's
            // pre-edge value, which is exactly the pipelined integrator chain.
            i1 <= i1 + x;
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_cnt <= '0;
        end else if (sync_i) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + DECIM_LOG2'(1);
        end
    end

    // A sync on the last phase wins: the strobe for that cycle is dropped.
    assign dec = (phase_cnt == '1) && !sync_i;

    cic_comb_stage u_comb1 (.clock(clock), .reset(reset), .en(dec), .din(i3), .dout(c1));
    cic_comb_stage u_comb2 (.clock(clock), .reset(reset), .en(dec), .din(c1), .dout(c2));
    cic_comb_stage u_comb3 (.clock(clock), .reset(reset), .en(dec), .din(c2), .dout(c3));

    // Gain R^3 = 4096 is doubled to reach the 14-bit full scale of the modulator input.
    assign y = wide_t'({c3, 1'b0});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= dec;
            if (dec) begin
                dout <= sat_out(y);
            end
        end
    end

`ifdef DECIM_CLIP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clip_o <= 1'b0;
        end else if (dec && out_of_range(y)) begin
            clip_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decim_cic.sv
// Self-checking bench for decim_cic: strobe timing every cycle, steady-state
// sample values for constant and periodic bitstreams, sync and async reset.
module tb_decim_cic;

    logic               clock  = 1'b0;
    logic               reset  = 1'b1;
    logic               ds_in  = 1'b0;
    logic               sync_i = 1'b0;
    logic signed [13:0] dout;
    logic               dout_valid;
`ifdef DECIM_CLIP_EN
    logic               clip_o;
`endif

    decim_cic dut (
        .clock      (clock),
        .reset      (reset),
        .ds_in      (ds_in),
        .sync_i     (sync_i),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef DECIM_CLIP_EN
        ,
        .clip_o     (clip_o)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        bit chk;
        int val;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int since    = 0;
    int n_strobe = 0;
    int pidx     = 0;
    bit hold_ok  = 1'b0;
    int hold_val = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_clip(input string tag, input bit exp);
`ifdef DECIM_CLIP_EN
        check(tag, {31'd0, clip_o}, {31'd0, exp});
`endif
    endtask

    // One clock: drive inputs, predict whether this edge strobes, then compare.
    task automatic step(input bit b, input bit s, input int exp_v);
        exp_t e;
        @(negedge clock);
        ds_in  = b;
        sync_i = s;
        cyc++;
        if (s) begin
            since    = 0;
            n_strobe = 0;
        end else begin
            since++;
            if (since == 16) begin
                since = 0;
                n_strobe++;
                sb.push_back('{cyc, (n_strobe >= 4), exp_v});
            end
        end
        @(posedge clock);
        #1;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("valid_hi", {31'd0, dout_valid}, 1);
            if (e.chk) begin
                check("dout", dout, e.val);
                hold_ok  = 1'b1;
                hold_val = e.val;
            end else begin
                hold_ok = 1'b0;
            end
        end else begin
            check("valid_lo", {31'd0, dout_valid}, 0);
            if (hold_ok) check("dout_hold", dout, hold_val);
        end
    endtask

    task automatic run_pat(input int n, input bit [7:0] pat, input int len,
                           input int exp_v, input int sync_at);
        for (int i = 0; i < n; i++) begin
            step(pat[pidx % len], (i == sync_at), exp_v);
            pidx++;
        end
    endtask

    // Asynchronous pulse placed between edges, spanning one rising edge.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", {31'd0, dout_valid}, 0);
        check_clip("rst_clip", 1'b0);
        @(posedge clock);
        cyc++;
        #3 reset = 1'b1;
        since    = 0;
        n_strobe = 0;
        hold_ok  = 1'b0;
        pidx     = 0;
        sb.delete();
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("init_dout", dout, 0);
        check("init_valid", {31'd0, dout_valid}, 0);
        check_clip("init_clip", 1'b0);
        #2 reset = 1'b1;

        // Constant -1: exact negative full scale, never clips.
        run_pat(16 * 8, 8'b0, 1, -8192, -1);
        check_clip("clip_neg", 1'b0);
        pulse_reset();

        // 1,0,1,0...: zero mean.
        run_pat(16 * 8, 8'b01, 2, 0, -1);
        check_clip("clip_alt", 1'b0);
        pulse_reset();

        // 1,1,1,0: mean +0.5, with a one-cycle sync at phase 7 mid-run.
        run_pat(16 * 6 + 7 + 1 + 16 * 6, 8'b0111, 4, 4096, 16 * 6 + 7);
        pulse_reset();

        // Constant +1 for 100 strobes: saturates to 8191.
        run_pat(16 * 100 + 5, 8'b1, 1, 8191, -1);
        check_clip("clip_pos", 1'b1);
        pulse_reset();
        run_pat(16 * 6, 8'b1, 1, 8191, -1);
        check_clip("clip_pos_again", 1'b1);

        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
